// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encodings and
// the default debounce window.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } sw_state_e;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 3;
    localparam int CNT_W                   = 4;

    // The datapath counts in both RUN and LAP; LAP only hides the display.
    function automatic logic is_counting(input sw_state_e s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// One pushbutton front end: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each accepted rising level.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
)
(
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             level_p2;
    logic [CNT_W-1:0] cnt_p2;

    // stage p0/p1: metastability guard
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    // stage p2: accept a level once it has differed from the current one
    // for DEBOUNCE_CYCLES consecutive samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_p2 <= 1'b0;
            cnt_p2   <= '0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_p1 == level_p2) begin
                cnt_p2 <= '0;
            end else if (cnt_p2 == CNT_LAST) begin
                level_p2 <= sync_p1;
                cnt_p2   <= '0;
                press    <= sync_p1;
            end else begin
                cnt_p2 <= cnt_p2 + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/lap/clear buttons drive a 4-state
// FSM whose registered outputs steer the stopwatch datapath.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic       at_max,
    output logic       sw_enable,
    output logic       sw_mode,
    output logic       sw_clear,
    output logic [1:0] state
);

    logic start_press;
    logic lap_press;
    logic clear_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_start),
        .press (start_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_lap),
        .press (lap_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_clear),
        .press (clear_press)
    );

    sw_state_e state_q;
    sw_state_e state_d;
    logic      enable_d;
    logic      mode_d;
    logic      clear_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sw_enable <= 1'b0;
            sw_mode   <= 1'b1;
            sw_clear  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sw_enable <= enable_d;
            sw_mode   <= mode_d;
            sw_clear  <= clear_d;
        end
    end

    // Outputs are decoded from the next state so they land with it.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_press) begin
                    clear_d = 1'b1;
                end else if (start_press) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (at_max || start_press) begin
                    state_d = PAUSE;
                end else if (lap_press) begin
                    state_d = LAP;
                end
            end
            LAP: begin
                if (at_max || start_press) begin
                    state_d = PAUSE;
                end else if (lap_press) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                // at_max only blocks restarting; clearing from max must work
                if (clear_press) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                end else if (start_press && !at_max) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        enable_d = is_counting(state_d);
        mode_d   = (state_d != LAP);
    end

    assign state = state_q;

endmodule
